// File: rtl/simple_dual_port_ram_pipelined_pkg.sv
// Shared types and elaboration helpers for the pipelined simple dual-port RAM.
package simple_dual_port_ram_pipelined_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   function automatic int nb_lanes(input int data_size, input int byte_size);
      return data_size / byte_size;
   endfunction

   // A one-word memory still needs a one-bit address bus.
   function automatic int addr_width(input int mem_size);
      return (mem_size > 1) ? $clog2(mem_size) : 1;
   endfunction

endpackage

// File: rtl/simple_dual_port_ram_pipelined_if.sv
// Write/read port bundle of the pipelined simple dual-port RAM.
interface simple_dual_port_ram_pipelined_if
   import simple_dual_port_ram_pipelined_pkg::*;
#(
   parameter int DATA_SIZE = 64,
   parameter int MEM_SIZE  = 1024,
   parameter int BYTE_SIZE = 8
);
   localparam int NB = nb_lanes(DATA_SIZE, BYTE_SIZE);
   localparam int AW = addr_width(MEM_SIZE);

   logic                 BUSY;
   logic                 ENA;
   logic [NB-1:0]        WEA;
   logic [AW-1:0]        ADDRA;
   logic [DATA_SIZE-1:0] DIA;
   logic                 ENB;
   logic [AW-1:0]        ADDRB;
   logic [DATA_SIZE-1:0] DOB;
   logic                 DOB_VALID;

   modport master (
      input  BUSY, DOB, DOB_VALID,
      output ENA, WEA, ADDRA, DIA, ENB, ADDRB
   );

   modport slave (
      output BUSY, DOB, DOB_VALID,
      input  ENA, WEA, ADDRA, DIA, ENB, ADDRB
   );

endinterface

// File: rtl/simple_dual_port_ram_pipelined_ram_clear_sequencer.sv
// Post-reset zero-fill sequencer: walks every word once and owns BUSY.
module simple_dual_port_ram_pipelined_ram_clear_sequencer
   import simple_dual_port_ram_pipelined_pkg::*;
#(
   parameter int MEM_SIZE     = 1024,
   parameter bit CLEAR_ON_RST = 1'b1,
   parameter int AW           = addr_width(MEM_SIZE)
) (
   input  logic          CLK,
   input  logic          RST,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_addr
);

   clr_state_t    state, state_nxt;
   logic [AW-1:0] clr_addr_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clr_en       = 1'b0;
      case (state)
         ST_CLEAR: begin
            // Memory is left untouched while RST is held.
            clr_en = !RST;
            if (32'(clr_addr) == MEM_SIZE - 1) state_nxt = ST_IDLE;
            else                               clr_addr_nxt = clr_addr + AW'(1);
         end
         default: ;
      endcase
   end

   assign busy = RST ? CLEAR_ON_RST : (state == ST_CLEAR);

endmodule

// File: rtl/simple_dual_port_ram_pipelined.sv
// Single-clock simple dual-port RAM: byte-enabled write port A, pipelined read
// port B with valid strobe, collision bypass and post-reset zero-fill.
module simple_dual_port_ram_pipelined
   import simple_dual_port_ram_pipelined_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int MEM_SIZE     = 1024,
   parameter int BYTE_SIZE    = 8,
   parameter int READ_LATENCY = 1,
   parameter bit WRITE_FIRST  = 1'b0,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input logic                             CLK,
   input logic                             RST,
   simple_dual_port_ram_pipelined_if.slave bus
);
   localparam int NB = nb_lanes(DATA_SIZE, BYTE_SIZE);
   localparam int AW = addr_width(MEM_SIZE);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("simple_dual_port_ram_pipelined: READ_LATENCY must be 1 or 2");
   end
   if (DATA_SIZE % BYTE_SIZE != 0) begin : g_bad_lanes
      $error("simple_dual_port_ram_pipelined: DATA_SIZE must be a multiple of BYTE_SIZE");
   end

   logic          busy, clr_en;
   logic [AW-1:0] clr_addr;

   simple_dual_port_ram_pipelined_ram_clear_sequencer #(
      .MEM_SIZE    (MEM_SIZE),
      .CLEAR_ON_RST(CLEAR_ON_RST),
      .AW          (AW)
   ) u_clr (
      .CLK     (CLK),
      .RST     (RST),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_addr(clr_addr)
   );

   assign bus.BUSY = busy;

   logic [DATA_SIZE-1:0] mem [MEM_SIZE];
   logic                 a_inr, b_inr, wr_ok, rd_acc;

   assign a_inr  = 32'(bus.ADDRA) < MEM_SIZE;
   assign b_inr  = 32'(bus.ADDRB) < MEM_SIZE;
   assign wr_ok  = bus.ENA && !busy && !RST && a_inr;
   assign rd_acc = bus.ENB && !busy;

   // Clear sequencer takes the write port ahead of user traffic.
   logic                 wa_en;
   logic [AW-1:0]        wa_addr;
   logic [NB-1:0]        wa_be;
   logic [DATA_SIZE-1:0] wa_data;

   always_comb begin
      wa_en   = clr_en | wr_ok;
      wa_addr = clr_en ? clr_addr : bus.ADDRA;
      wa_be   = clr_en ? '1 : bus.WEA;
      wa_data = clr_en ? '0 : bus.DIA;
   end

   always_ff @(posedge CLK) begin
      if (wa_en)
         for (int i = 0; i < NB; i++)
            if (wa_be[i]) mem[wa_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wa_data[i*BYTE_SIZE +: BYTE_SIZE];
   end

   // Out-of-range reads return zero; write-first forwards only enabled lanes.
   logic [DATA_SIZE-1:0] rd_data;

   always_comb begin
      rd_data = '0;
      if (b_inr) begin
         rd_data = mem[bus.ADDRB];
         if (WRITE_FIRST && wr_ok && bus.ADDRA == bus.ADDRB)
            for (int i = 0; i < NB; i++)
               if (bus.WEA[i]) rd_data[i*BYTE_SIZE +: BYTE_SIZE] = bus.DIA[i*BYTE_SIZE +: BYTE_SIZE];
      end
   end

   logic                 s1_vld;
   logic [DATA_SIZE-1:0] s1_dat;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else begin
         s1_vld <= rd_acc;
         if (rd_acc) s1_dat <= rd_data;
      end
   end

   if (READ_LATENCY == 2) begin : g_out_reg
      logic                 s2_vld;
      logic [DATA_SIZE-1:0] s2_dat;

      always_ff @(posedge CLK) begin
         if (RST) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
         end else begin
            s2_vld <= s1_vld;
            if (s1_vld) s2_dat <= s1_dat;
         end
      end

      assign bus.DOB       = s2_dat;
      assign bus.DOB_VALID = s2_vld;
   end else begin : g_no_out_reg
      assign bus.DOB       = s1_dat;
      assign bus.DOB_VALID = s1_vld;
   end

endmodule

// File: tb/tb_simple_dual_port_ram_pipelined.sv
// Drives two RAM configurations with identical stimulus and checks each
// against its own behavioural memory model.
module tb_simple_dual_port_ram_pipelined;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic        ena, enb;
   logic [7:0]  wea;
   logic [3:0]  adda, addb;
   logic [63:0] dia;

   // inst 0: 12 words, latency 1, read-first; inst 1: 16 words, latency 2, write-first
   simple_dual_port_ram_pipelined_if #(.DATA_SIZE(64), .MEM_SIZE(12), .BYTE_SIZE(8)) if0 ();
   simple_dual_port_ram_pipelined_if #(.DATA_SIZE(64), .MEM_SIZE(16), .BYTE_SIZE(8)) if1 ();

   assign if0.ENA = ena;  assign if0.WEA = wea;  assign if0.ADDRA = adda;
   assign if0.DIA = dia;  assign if0.ENB = enb;  assign if0.ADDRB = addb;
   assign if1.ENA = ena;  assign if1.WEA = wea;  assign if1.ADDRA = adda;
   assign if1.DIA = dia;  assign if1.ENB = enb;  assign if1.ADDRB = addb;

   simple_dual_port_ram_pipelined #(
      .DATA_SIZE(64), .MEM_SIZE(12), .BYTE_SIZE(8),
      .READ_LATENCY(1), .WRITE_FIRST(1'b0), .CLEAR_ON_RST(1'b1)
   ) dut0 (.CLK(CLK), .RST(RST), .bus(if0));

   simple_dual_port_ram_pipelined #(
      .DATA_SIZE(64), .MEM_SIZE(16), .BYTE_SIZE(8),
      .READ_LATENCY(2), .WRITE_FIRST(1'b1), .CLEAR_ON_RST(1'b1)
   ) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

   logic        busy_o [2];
   logic        vld_o  [2];
   logic [63:0] dob_o  [2];
   assign busy_o[0] = if0.BUSY;  assign vld_o[0] = if0.DOB_VALID;  assign dob_o[0] = if0.DOB;
   assign busy_o[1] = if1.BUSY;  assign vld_o[1] = if1.DOB_VALID;  assign dob_o[1] = if1.DOB;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   localparam int SL = 8;
   int          edge_n = 0;
   logic [63:0] m_mem [2][16];
   int          m_busy [2];
   logic [63:0] m_dob  [2];
   logic        m_vld  [2];
   bit          sch_v  [2][SL];
   logic [63:0] sch_d  [2][SL];

   function automatic int ms(input int i);  return (i == 0) ? 12 : 16; endfunction
   function automatic int lat(input int i); return (i == 0) ? 1 : 2;   endfunction
   function automatic bit wf(input int i);  return (i == 1);           endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_dob[i] = '0; m_vld[i] = 1'b0;
         for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
         for (int k = 0; k < SL; k++) begin sch_v[i][k] = 1'b0; sch_d[i][k] = '0; end
      end
   end

   // One clock: edge, model update from the inputs seen at that edge, then
   // return at the falling edge where outputs are sampled and inputs changed.
   task automatic tick();
      @(posedge CLK);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            m_busy[i] = ms(i);
            m_dob[i]  = '0;
            m_vld[i]  = 1'b0;
            for (int k = 0; k < 3; k++) sch_v[i][(edge_n + k) % SL] = 1'b0;
         end else begin
            if (m_busy[i] > 0) begin
               m_busy[i]--;
               if (m_busy[i] == 0) for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
            end else begin
               if (enb) begin
                  logic [63:0] rd;
                  int slot;
                  rd = (int'(addb) < ms(i)) ? m_mem[i][addb] : 64'h0;
                  if (wf(i) && ena && adda == addb && int'(addb) < ms(i))
                     for (int b = 0; b < 8; b++) if (wea[b]) rd[b*8 +: 8] = dia[b*8 +: 8];
                  slot = (edge_n + lat(i) - 1) % SL;
                  sch_v[i][slot] = 1'b1;
                  sch_d[i][slot] = rd;
               end
               if (ena && int'(adda) < ms(i))
                  for (int b = 0; b < 8; b++) if (wea[b]) m_mem[i][adda][b*8 +: 8] = dia[b*8 +: 8];
            end
            m_vld[i] = sch_v[i][edge_n % SL];
            if (m_vld[i]) begin
               m_dob[i] = sch_d[i][edge_n % SL];
               sch_v[i][edge_n % SL] = 1'b0;
            end
         end
      end
      @(negedge CLK);
   endtask

   task automatic drive(input logic e_a, input logic [7:0] w, input logic [3:0] aa,
                        input logic [63:0] d, input logic e_b, input logic [3:0] ab);
      ena = e_a; wea = w; adda = aa; dia = d; enb = e_b; addb = ab;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 4'h0);
   endtask

   // Ticks until both instances drop BUSY; returns tick counts (-1 on timeout).
   task automatic measure_fall(output int f0, output int f1);
      f0 = -1; f1 = -1;
      for (int t = 1; t <= 64 && (f0 < 0 || f1 < 0); t++) begin
         tick();
         if (f0 < 0 && busy_o[0] === 1'b0) f0 = t;
         if (f1 < 0 && busy_o[1] === 1'b0) f1 = t;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int f0, f1;
      RST = 1'b1; idle();
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_o[i] !== 1'b1 || vld_o[i] !== 1'b0 || dob_o[i] !== 64'h0) begin
            n_bad++;
            $display("FAIL reset[%0d] busy/vld/dob got %b/%b/%h want 1/0/0", i, busy_o[i], vld_o[i], dob_o[i]);
         end
      end
      RST = 1'b0;
      measure_fall(f0, f1);
      n_cmp++;
      if (f0 != ms(0)) begin n_bad++; $display("FAIL busy_len[0] got %0d want %0d", f0, ms(0)); end
      n_cmp++;
      if (f1 != ms(1)) begin n_bad++; $display("FAIL busy_len[1] got %0d want %0d", f1, ms(1)); end
   endtask

   task automatic test_clear_fill();
      int f0, f1;
      for (int a = 0; a < 16; a++) begin
         drive(1'b1, 8'hFF, 4'(a), 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 4'h0);
         tick();
      end
      drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'h7);
      tick(); idle(); tick(); tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dob_o[i] !== m_dob[i]) begin
            n_bad++; $display("FAIL preload[%0d] dob got %h want %h", i, dob_o[i], m_dob[i]);
         end
      end
      RST = 1'b1; tick(); RST = 1'b0;
      measure_fall(f0, f1);
      n_cmp++;
      if (f0 != ms(0)) begin n_bad++; $display("FAIL refill_len[0] got %0d want %0d", f0, ms(0)); end
      n_cmp++;
      if (f1 != ms(1)) begin n_bad++; $display("FAIL refill_len[1] got %0d want %0d", f1, ms(1)); end
      for (int a = 0; a < 19; a++) begin
         if (a < 16) drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'(a)); else idle();
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL cleared[%0d] cyc %0d vld/dob got %b/%h want %b/%h", i, a, vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
   endtask

   task automatic test_byte_enable();
      drive(1'b1, 8'b0000_0101, 4'd3, 64'h1111_2222_3333_4444, 1'b0, 4'h0);
      tick();
      drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'd3);
      tick(); idle(); tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dob_o[i] !== 64'h0000_0000_0033_0044 || dob_o[i] !== m_dob[i]) begin
            n_bad++; $display("FAIL byte_en[%0d] dob got %h want %h", i, dob_o[i], 64'h0000_0000_0033_0044);
         end
      end
   endtask

   task automatic test_back_to_back();
      int nv [2];
      nv[0] = 0; nv[1] = 0;
      for (int a = 0; a < 4; a++) begin
         drive(1'b1, 8'hFF, 4'(a), {$urandom, $urandom}, 1'b0, 4'h0);
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         if (c < 4) drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'(c)); else idle();
         tick();
         for (int i = 0; i < 2; i++) begin
            if (vld_o[i] === 1'b1) nv[i]++;
            n_cmp++;
            if (vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL b2b[%0d] cyc %0d vld/dob got %b/%h want %b/%h", i, c, vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (nv[i] != 4) begin n_bad++; $display("FAIL b2b_count[%0d] got %0d want 4", i, nv[i]); end
      end
   endtask

   task automatic test_collision();
      logic [63:0] pat;
      pat = {$urandom, $urandom};
      drive(1'b1, 8'hFF, 4'd6, pat, 1'b0, 4'h0);
      tick();
      for (int c = 0; c < 9; c++) begin
         case (c)
            0: drive(1'b1, 8'hFF, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd5);
            3: drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'd5);
            5: drive(1'b1, 8'h3C, 4'd6, ~pat, 1'b1, 4'd6);
            7: drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'd6);
            default: idle();
         endcase
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL collide[%0d] cyc %0d vld/dob got %b/%h want %b/%h", i, c, vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
   endtask

   task automatic test_busy_drop();
      int f [2];
      RST = 1'b1; idle(); tick(); RST = 1'b0;
      for (int c = 0; c < 9; c++) tick();
      RST = 1'b1; tick(); RST = 1'b0;
      f[0] = -1; f[1] = -1;
      for (int t = 1; t <= 64 && (f[0] < 0 || f[1] < 0); t++) begin
         if (t <= 11) drive(1'b1, 8'hFF, 4'(t), 64'hDEAD_BEEF_0000_0000 | 64'(t), 1'b1, 4'(t));
         else         idle();
         tick();
         for (int i = 0; i < 2; i++) begin
            if (f[i] < 0 && busy_o[i] === 1'b0) f[i] = t;
            n_cmp++;
            if (busy_o[i] !== (m_busy[i] > 0) || vld_o[i] !== m_vld[i]) begin
               n_bad++;
               $display("FAIL busy_drop[%0d] t %0d busy/vld got %b/%b want %b/%b", i, t, busy_o[i], vld_o[i], m_busy[i] > 0, m_vld[i]);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (f[i] != ms(i)) begin n_bad++; $display("FAIL restart_len[%0d] got %0d want %0d", i, f[i], ms(i)); end
      end
      for (int a = 0; a < 18; a++) begin
         if (a < 16) drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'(a)); else idle();
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL after_drop[%0d] cyc %0d vld/dob got %b/%h want %b/%h", i, a, vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 8'hFF, 4'd13, 64'h5, 1'b0, 4'h0);
      tick();
      for (int a = 0; a < 18; a++) begin
         if (a < 16) drive(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'((a + 13) % 16)); else idle();
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL oob[%0d] cyc %0d vld/dob got %b/%h want %b/%h", i, a, vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         logic [3:0] aa, ab;
         aa = 4'($urandom_range(0, 15));
         ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
         drive(1'($urandom), 8'($urandom), aa, {$urandom, $urandom}, 1'($urandom), ab);
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (busy_o[i] !== 1'b0 || vld_o[i] !== m_vld[i] || dob_o[i] !== m_dob[i]) begin
               n_bad++;
               $display("FAIL random[%0d] cyc %0d busy/vld/dob got %b/%b/%h want 0/%b/%h", i, c, busy_o[i], vld_o[i], dob_o[i], m_vld[i], m_dob[i]);
            end
         end
      end
      idle();
   endtask

   initial begin
      RST = 1'b1;
      idle();
      test_reset();
      test_clear_fill();
      test_byte_enable();
      test_back_to_back();
      test_collision();
      test_busy_drop();
      test_out_of_range();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
